// File: rtl/idu_pkg.sv
// Shared opcodes and decode selector types for the ID stage.
// The W opcodes are legal only on RV64 cores built with word ops enabled.
package idu_pkg;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_type_e;
  typedef enum logic [1:0] {SRC1_ZERO, SRC1_PC, SRC1_RS1} src1_sel_e;
  typedef enum logic {SRC2_IMM, SRC2_RS2} src2_sel_e;

endpackage

// File: rtl/idu_imm_gen.sv
// Immediate generator: every format fits in 32 signed bits,
// so it is assembled at 32 bits and sign-extended to XLEN afterwards.
module idu_imm_gen
  import idu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  input  imm_type_e       imm_type,
  output logic [XLEN-1:0] imm
);

  logic signed [31:0] w_imm32;
  logic               w_unused;

  assign w_unused = ^inst[6:0];

  always_comb begin
    w_imm32 = '0;
    case (imm_type)
      IMM_I:   w_imm32 = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   w_imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   w_imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   w_imm32 = {inst[31:12], 12'b0};
      IMM_J:   w_imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

  assign imm = XLEN'(w_imm32);

endmodule

// File: rtl/idu_pipe.sv
// Decode stage with ID/EX output register: valid/ready on both sides,
// load-use stall, flush and illegal-opcode flagging.
module idu_pipe
  import idu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int RV64_W_OPS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] reg_rdata1,
  input  logic [XLEN-1:0] reg_rdata2,
  input  logic            ex_valid,
  input  logic [4:0]      ex_rd,
  input  logic            ex_is_load,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_src1,
  output logic [XLEN-1:0] out_src2,
  output logic [XLEN-1:0] out_store_data,
  output logic [4:0]      out_rd,
  output logic            out_reg_wen,
  output logic            out_jump,
  output logic            out_branch,
  output logic            out_mem_ren,
  output logic            out_mem_wen,
  output logic [2:0]      out_funct3,
  output logic            out_funct7b5,
  output logic            out_word_op,
  output logic            out_illegal
);

  localparam bit W_OK = (XLEN == 64) && (RV64_W_OPS != 0);

  logic [6:0]      w_opcode;
  logic [4:0]      w_rd;
  imm_type_e       w_imm_type;
  src1_sel_e       w_src1_sel;
  src2_sel_e       w_src2_sel;
  logic            w_known, w_writes, w_jump, w_branch, w_load, w_store;
  logic            w_uses_rs1, w_uses_rs2, w_is_w, w_illegal, w_hazard, w_fire;
  logic [XLEN-1:0] w_imm, w_src1, w_src2;

  logic            r_out_valid;
  logic [XLEN-1:0] r_out_pc, r_out_src1, r_out_src2, r_out_store_data;
  logic [4:0]      r_out_rd;
  logic            r_out_reg_wen, r_out_jump, r_out_branch, r_out_mem_ren, r_out_mem_wen;
  logic [2:0]      r_out_funct3;
  logic            r_out_funct7b5, r_out_word_op, r_out_illegal;

  assign w_opcode = inst[6:0];
  assign w_rd     = inst[11:7];
  assign rs1_addr = inst[19:15];
  assign rs2_addr = inst[24:20];

  always_comb begin
    w_imm_type = IMM_NONE;
    w_src1_sel = SRC1_RS1;
    w_src2_sel = SRC2_IMM;
    w_known    = 1'b1;
    w_writes   = 1'b0;
    w_jump     = 1'b0;
    w_branch   = 1'b0;
    w_load     = 1'b0;
    w_store    = 1'b0;
    w_uses_rs1 = 1'b1;
    w_uses_rs2 = 1'b0;
    w_is_w     = 1'b0;
    case (w_opcode)
      OPC_LUI:       begin w_imm_type = IMM_U; w_src1_sel = SRC1_ZERO; w_writes = 1'b1; w_uses_rs1 = 1'b0; end
      OPC_AUIPC:     begin w_imm_type = IMM_U; w_src1_sel = SRC1_PC; w_writes = 1'b1; w_uses_rs1 = 1'b0; end
      OPC_JAL:       begin w_imm_type = IMM_J; w_src1_sel = SRC1_PC; w_writes = 1'b1; w_jump = 1'b1; w_uses_rs1 = 1'b0; end
      OPC_JALR:      begin w_imm_type = IMM_I; w_writes = 1'b1; w_jump = 1'b1; end
      OPC_BRANCH:    begin w_imm_type = IMM_B; w_src2_sel = SRC2_RS2; w_branch = 1'b1; w_uses_rs2 = 1'b1; end
      OPC_LOAD:      begin w_imm_type = IMM_I; w_writes = 1'b1; w_load = 1'b1; end
      OPC_STORE:     begin w_imm_type = IMM_S; w_store = 1'b1; w_uses_rs2 = 1'b1; end
      OPC_OP_IMM:    begin w_imm_type = IMM_I; w_writes = 1'b1; end
      OPC_OP:        begin w_src2_sel = SRC2_RS2; w_writes = 1'b1; w_uses_rs2 = 1'b1; end
      OPC_OP_IMM_32: begin w_imm_type = IMM_I; w_writes = 1'b1; w_is_w = 1'b1; end
      OPC_OP_32:     begin w_src2_sel = SRC2_RS2; w_writes = 1'b1; w_uses_rs2 = 1'b1; w_is_w = 1'b1; end
      default:       w_known = 1'b0;
    endcase
  end

  assign w_illegal = !w_known || (inst[1:0] != 2'b11) || (w_is_w && !W_OK);

  idu_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst     (inst),
    .imm_type (w_imm_type),
    .imm      (w_imm)
  );

  always_comb begin
    case (w_src1_sel)
      SRC1_ZERO: w_src1 = '0;
      SRC1_PC:   w_src1 = pc;
      default:   w_src1 = reg_rdata1;
    endcase
    w_src2 = (w_src2_sel == SRC2_RS2) ? reg_rdata2 : w_imm;
  end

  // A load in EXU cannot forward yet, so any consumer of its rd must wait a cycle.
  assign w_hazard = ex_valid && ex_is_load && (ex_rd != 5'd0) &&
                    ((w_uses_rs1 && (rs1_addr == ex_rd)) || (w_uses_rs2 && (rs2_addr == ex_rd)));

  assign in_ready = !rst && !flush && !w_hazard && (!r_out_valid || out_ready);
  assign w_fire   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid      <= 1'b0;
      r_out_pc         <= '0;
      r_out_src1       <= '0;
      r_out_src2       <= '0;
      r_out_store_data <= '0;
      r_out_rd         <= '0;
      r_out_reg_wen    <= 1'b0;
      r_out_jump       <= 1'b0;
      r_out_branch     <= 1'b0;
      r_out_mem_ren    <= 1'b0;
      r_out_mem_wen    <= 1'b0;
      r_out_funct3     <= '0;
      r_out_funct7b5   <= 1'b0;
      r_out_word_op    <= 1'b0;
      r_out_illegal    <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_fire) begin
      // Illegal instructions still travel down so EXU can raise the trap.
      r_out_valid      <= 1'b1;
      r_out_pc         <= pc;
      r_out_src1       <= w_src1;
      r_out_src2       <= w_src2;
      r_out_store_data <= reg_rdata2;
      r_out_rd         <= w_rd;
      r_out_reg_wen    <= w_writes && !w_illegal && (w_rd != 5'd0);
      r_out_jump       <= w_jump && !w_illegal;
      r_out_branch     <= w_branch && !w_illegal;
      r_out_mem_ren    <= w_load && !w_illegal;
      r_out_mem_wen    <= w_store && !w_illegal;
      r_out_funct3     <= inst[14:12];
      r_out_funct7b5   <= inst[30];
      r_out_word_op    <= w_is_w && !w_illegal;
      r_out_illegal    <= w_illegal;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid      = r_out_valid;
  assign out_pc         = r_out_pc;
  assign out_src1       = r_out_src1;
  assign out_src2       = r_out_src2;
  assign out_store_data = r_out_store_data;
  assign out_rd         = r_out_rd;
  assign out_reg_wen    = r_out_reg_wen;
  assign out_jump       = r_out_jump;
  assign out_branch     = r_out_branch;
  assign out_mem_ren    = r_out_mem_ren;
  assign out_mem_wen    = r_out_mem_wen;
  assign out_funct3     = r_out_funct3;
  assign out_funct7b5   = r_out_funct7b5;
  assign out_word_op    = r_out_word_op;
  assign out_illegal    = r_out_illegal;

endmodule

// File: tb/tb_idu_pipe.sv
// Bench for idu_pipe: a 32-bit and a 64-bit instance share stimulus and
// are compared against an instruction-level reference model.
module tb_idu_pipe;

  localparam logic [6:0] L_LUI = 7'h37, L_AUIPC = 7'h17, L_JAL = 7'h6F, L_JALR = 7'h67;
  localparam logic [6:0] L_BR = 7'h63, L_LOAD = 7'h03, L_STORE = 7'h23, L_OPIMM = 7'h13;
  localparam logic [6:0] L_OP = 7'h33, L_OPIMM32 = 7'h1B, L_OP32 = 7'h3B;

  typedef struct {
    logic [63:0] pc, src1, src2, sd;
    logic [4:0]  rd;
    logic        wen, jump, br, ren, mwen;
    logic [2:0]  f3;
    logic        f7, word, ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, ex_valid, ex_is_load, flush, out_ready;
  logic [31:0] inst;
  logic [63:0] pc, rdata1, rdata2;
  logic [4:0]  ex_rd;

  logic        a_in_ready, a_valid, a_wen, a_jump, a_br, a_ren, a_mwen, a_f7, a_word, a_ill;
  logic [4:0]  a_rs1, a_rs2, a_rd;
  logic [31:0] a_pc, a_src1, a_src2, a_sd;
  logic [2:0]  a_f3;
  logic        b_in_ready, b_valid, b_wen, b_jump, b_br, b_ren, b_mwen, b_f7, b_word, b_ill;
  logic [4:0]  b_rs1, b_rs2, b_rd;
  logic [63:0] b_pc, b_src1, b_src2, b_sd;
  logic [2:0]  b_f3;

  int   total = 0;
  int   bad = 0;
  logic mv = 1'b0;
  exp_t e32, e64;

  always #5 clk = ~clk;

  idu_pipe #(.XLEN(32), .RV64_W_OPS(1)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .inst(inst),
    .pc(pc[31:0]), .rs1_addr(a_rs1), .rs2_addr(a_rs2), .reg_rdata1(rdata1[31:0]),
    .reg_rdata2(rdata2[31:0]), .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
    .flush(flush), .out_valid(a_valid), .out_ready(out_ready), .out_pc(a_pc),
    .out_src1(a_src1), .out_src2(a_src2), .out_store_data(a_sd), .out_rd(a_rd),
    .out_reg_wen(a_wen), .out_jump(a_jump), .out_branch(a_br), .out_mem_ren(a_ren),
    .out_mem_wen(a_mwen), .out_funct3(a_f3), .out_funct7b5(a_f7), .out_word_op(a_word),
    .out_illegal(a_ill)
  );

  idu_pipe #(.XLEN(64), .RV64_W_OPS(1)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .inst(inst),
    .pc(pc), .rs1_addr(b_rs1), .rs2_addr(b_rs2), .reg_rdata1(rdata1),
    .reg_rdata2(rdata2), .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
    .flush(flush), .out_valid(b_valid), .out_ready(out_ready), .out_pc(b_pc),
    .out_src1(b_src1), .out_src2(b_src2), .out_store_data(b_sd), .out_rd(b_rd),
    .out_reg_wen(b_wen), .out_jump(b_jump), .out_branch(b_br), .out_mem_ren(b_ren),
    .out_mem_wen(b_mwen), .out_funct3(b_f3), .out_funct7b5(b_f7), .out_word_op(b_word),
    .out_illegal(b_ill)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t zeroExp();
    exp_t e;
    e.pc = '0; e.src1 = '0; e.src2 = '0; e.sd = '0; e.rd = '0;
    e.wen = 0; e.jump = 0; e.br = 0; e.ren = 0; e.mwen = 0;
    e.f3 = '0; e.f7 = 0; e.word = 0; e.ill = 0;
    return e;
  endfunction

  // Instruction-level meaning of one RISC-V word for a core of width xlen.
  function automatic exp_t decode(input logic [31:0] ins, input logic [63:0] p, d1, d2, input int xlen);
    exp_t e;
    logic [6:0] op;
    logic signed [11:0] i12, s12;
    logic signed [12:0] b13;
    logic signed [20:0] j21;
    logic signed [31:0] u32;
    logic signed [63:0] imm;
    logic [63:0] mask;
    bit isw, ill;
    op  = ins[6:0];
    i12 = ins[31:20];
    s12 = {ins[31:25], ins[11:7]};
    b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    j21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    u32 = {ins[31:12], 12'h000};
    imm = 64'sd0;
    if (op inside {L_OPIMM, L_OPIMM32, L_LOAD, L_JALR}) imm = i12;
    else if (op == L_STORE) imm = s12;
    else if (op == L_BR) imm = b13;
    else if (op inside {L_LUI, L_AUIPC}) imm = u32;
    else if (op == L_JAL) imm = j21;
    isw  = (op == L_OPIMM32) || (op == L_OP32);
    ill  = !(op inside {L_LUI, L_AUIPC, L_JAL, L_JALR, L_BR, L_LOAD, L_STORE, L_OPIMM, L_OP, L_OPIMM32, L_OP32})
           || (ins[1:0] != 2'b11) || (isw && xlen != 64);
    mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    e.pc   = p & mask;
    e.src1 = ((op == L_LUI) ? 64'd0 : (op inside {L_AUIPC, L_JAL}) ? p : d1) & mask;
    e.src2 = ((op inside {L_OP, L_OP32, L_BR}) ? d2 : imm) & mask;
    e.sd   = d2 & mask;
    e.rd   = ins[11:7];
    e.wen  = !ill && (ins[11:7] != 5'd0) &&
             (op inside {L_LUI, L_AUIPC, L_JAL, L_JALR, L_OPIMM, L_OP, L_LOAD, L_OPIMM32, L_OP32});
    e.jump = !ill && (op inside {L_JAL, L_JALR});
    e.br   = !ill && (op == L_BR);
    e.ren  = !ill && (op == L_LOAD);
    e.mwen = !ill && (op == L_STORE);
    e.f3   = ins[14:12];
    e.f7   = ins[30];
    e.word = isw && !ill;
    e.ill  = ill;
    return e;
  endfunction

  function automatic bit hazardOf(input logic [31:0] ins, input logic exv, exl, input logic [4:0] exrd);
    logic [6:0] op;
    bit u1, u2;
    op = ins[6:0];
    u1 = !(op inside {L_LUI, L_AUIPC, L_JAL});
    u2 = op inside {L_OP, L_OP32, L_STORE, L_BR};
    return exv && exl && (exrd != 0) && ((u1 && ins[19:15] == exrd) || (u2 && ins[24:20] == exrd));
  endfunction

  task automatic checkOutput();
    chk("out_valid32", a_valid, mv);
    chk("out_valid64", b_valid, mv);
    if (mv) begin
      chk("pc32", a_pc, e32.pc);       chk("pc64", b_pc, e64.pc);
      chk("src1_32", a_src1, e32.src1); chk("src1_64", b_src1, e64.src1);
      chk("src2_32", a_src2, e32.src2); chk("src2_64", b_src2, e64.src2);
      chk("sd32", a_sd, e32.sd);       chk("sd64", b_sd, e64.sd);
      chk("rd", b_rd, e64.rd);         chk("f3", b_f3, e64.f3);
      chk("f7b5", b_f7, e64.f7);
      chk("ctl32", {a_wen, a_jump, a_br, a_ren, a_mwen, a_word, a_ill},
          {e32.wen, e32.jump, e32.br, e32.ren, e32.mwen, e32.word, e32.ill});
      chk("ctl64", {b_wen, b_jump, b_br, b_ren, b_mwen, b_word, b_ill},
          {e64.wen, e64.jump, e64.br, e64.ren, e64.mwen, e64.word, e64.ill});
    end
  endtask

  task automatic applyStimulus(input logic r, iv, input logic [31:0] ins, input logic [63:0] p, d1, d2,
                               input logic exv, exl, input logic [4:0] exrd, input logic fl, ordy);
    bit rdy;
    rst = r; in_valid = iv; inst = ins; pc = p; rdata1 = d1; rdata2 = d2;
    ex_valid = exv; ex_is_load = exl; ex_rd = exrd; flush = fl; out_ready = ordy;
    #1;
    rdy = !r && !fl && !hazardOf(ins, exv, exl, exrd) && (!mv || ordy);
    chk("in_ready32", a_in_ready, rdy);
    chk("in_ready64", b_in_ready, rdy);
    chk("rs_addr", {a_rs1, a_rs2, b_rs1, b_rs2}, {ins[19:15], ins[24:20], ins[19:15], ins[24:20]});
    if (r) begin
      mv = 0; e32 = zeroExp(); e64 = zeroExp();
    end else if (fl) begin
      mv = 0;
    end else if (iv && rdy) begin
      mv = 1;
      e32 = decode(ins, p, d1, d2, 32);
      e64 = decode(ins, p, d1, d2, 64);
    end else if (ordy) begin
      mv = 0;
    end
    @(posedge clk);
    #1;
    checkOutput();
    @(negedge clk);
  endtask

  initial begin
    logic [6:0]  opTab [11];
    logic [31:0] ri;
    int          k;
    opTab[0] = L_LUI;  opTab[1] = L_AUIPC; opTab[2] = L_JAL;   opTab[3] = L_JALR;
    opTab[4] = L_BR;   opTab[5] = L_LOAD;  opTab[6] = L_STORE; opTab[7] = L_OPIMM;
    opTab[8] = L_OP;   opTab[9] = L_OPIMM32; opTab[10] = L_OP32;
    e32 = zeroExp(); e64 = zeroExp();
    rst = 1; in_valid = 0; inst = '0; pc = '0; rdata1 = '0; rdata2 = '0;
    ex_valid = 0; ex_is_load = 0; ex_rd = '0; flush = 0; out_ready = 0;
    @(negedge clk);

    $display("[TB] reset");
    applyStimulus(1, 1, 32'h00000013, 64'h40, 64'h5, 64'h6, 0, 0, 0, 0, 1);
    applyStimulus(1, 1, 32'h00000013, 64'h40, 64'h5, 64'h6, 0, 0, 0, 0, 1);
    chk("rst_zero_a", {a_pc, a_src1, a_src2, a_sd}, '0);
    chk("rst_zero_b", b_src2 | b_pc | b_src1 | b_sd, '0);
    chk("rst_zero_ctl", {a_rd, a_wen, a_jump, a_br, a_ren, a_mwen, a_f3, a_f7, a_word, a_ill}, '0);

    $display("[TB] addi / auipc");
    applyStimulus(0, 1, 32'hFFF00093, 64'h80000000, 64'h0, 64'h0, 0, 0, 0, 0, 1);
    chk("addi_src1", a_src1, 64'h0);
    chk("addi_src2", a_src2, 64'hFFFFFFFF);
    chk("addi_rd_wen", {a_rd, a_wen, a_valid}, {5'd1, 1'b1, 1'b1});
    applyStimulus(0, 1, 32'h80000117, 64'h80000004, 64'h1234, 64'h0, 0, 0, 0, 0, 1);
    chk("auipc_src1", b_src1, 64'h80000004);
    chk("auipc_src2", b_src2, 64'hFFFFFFFF80000000);
    chk("auipc_wen", b_wen, 1'b1);

    $display("[TB] load-use stall");
    applyStimulus(0, 1, 32'h00728333, 64'h80000008, 64'hAAAA, 64'hBBBB, 1, 1, 5'd5, 0, 1);
    chk("lu_bubble", a_valid, 1'b0);
    chk("lu_stall", a_in_ready, 1'b0);
    applyStimulus(0, 1, 32'h00728333, 64'h80000008, 64'hAAAA, 64'hBBBB, 0, 1, 5'd5, 0, 1);
    chk("lu_issue", {a_valid, a_rd, a_src1, a_src2}, {1'b1, 5'd6, 32'hAAAA, 32'hBBBB});

    $display("[TB] backpressure");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 32'h00508193, 64'h8000000C, 64'h11, 64'h22, 0, 0, 0, 0, 0);
      chk("bp_hold", {a_valid, a_rd, a_src2}, {1'b1, 5'd6, 32'hBBBB});
    end
    applyStimulus(0, 1, 32'h00508193, 64'h8000000C, 64'h11, 64'h22, 0, 0, 0, 0, 1);
    chk("bp_accept", {a_rd, a_src1, a_src2}, {5'd3, 32'h11, 32'h5});

    $display("[TB] flush");
    applyStimulus(0, 1, 32'h00412203, 64'h80000010, 64'h30, 64'h40, 0, 0, 0, 1, 0);
    chk("flush_kill", {a_valid, b_valid}, 2'b00);
    applyStimulus(0, 0, 32'h00412203, 64'h80000010, 64'h30, 64'h40, 0, 0, 0, 0, 1);

    $display("[TB] word ops and x0");
    applyStimulus(0, 1, 32'h0010809B, 64'h80000014, 64'h7, 64'h0, 0, 0, 0, 0, 1);
    chk("addiw32", {a_valid, a_ill, a_wen}, 3'b110);
    chk("addiw64", {b_valid, b_ill, b_wen, b_word}, 4'b1011);
    applyStimulus(0, 1, 32'h00000013, 64'h80000018, 64'h0, 64'h0, 0, 0, 0, 0, 1);
    chk("nop_wen", {a_valid, a_wen}, 2'b10);

    $display("[TB] random");
    for (int n = 0; n < 3000; n++) begin
      ri = $urandom;
      ri[19:15] = 5'($urandom_range(0, 7));
      ri[24:20] = 5'($urandom_range(0, 7));
      ri[11:7]  = 5'($urandom_range(0, 3));
      k = $urandom_range(0, 11);
      if (k < 11) ri[6:0] = opTab[k];
      applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), ri,
                    {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                    ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
